imm_gen_pipe: RTL and testbench

//  Registered, XLEN-parametrised immediate generator for the decode stage.
//  - Accepts one instruction per cycle over a valid/ready handshake; decodes and extends its immediate.
//  - Emits the immediate plus a type tag one cycle later.
//  - A 2-entry skid buffer absorbs back-pressure without a combinational ready path.
//  - Successor of the combinational RV64 immediate unit.

---
 rtl/imm_pkg.sv | 34 +++
 rtl/imm_decode.sv | 91 +++++++++
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// The optional CSR-immediate decode is selected with the macro IMM_CSR_UIMM_EN.
package imm_pkg;

  localparam int INST_WIDTH = 32;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_UIMM  = 3'd7
  } imm_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Every sign-extended immediate fits in 32 bits; widen it to the 64-bit working value.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: raw instruction -> extended immediate and type tag.
// Honours IMM_CSR_UIMM_EN (CSR zimm field decoded as IMM_UIMM when defined).
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       type_o
);

  logic [63:0] imm_full;
  logic [2:0]  funct3;

  assign funct3 = instr_i[14:12];

  // Decode the opcode into a 64-bit working immediate, then trim to XLEN.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    imm_full = '0;
    type_o   = IMM_NONE;
    case (instr_i[6:0])
      OP_LUI, OP_AUIPC: begin
        imm_full = sext32({instr_i[31:12], 12'b0});
        type_o   = IMM_U;
      end
      OP_JAL: begin
        imm_full = sext32({{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0});
        type_o   = IMM_J;
      end
      OP_JALR, OP_LOAD: begin
        imm_full = sext32({{20{instr_i[31]}}, instr_i[31:20]});
        type_o   = IMM_I;
      end
      OP_BRANCH: begin
        imm_full = sext32({{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0});
        type_o   = IMM_B;
      end
      OP_STORE: begin
        imm_full = sext32({{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]});
        type_o   = IMM_S;
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // RV64 shifts use a 6-bit shamt, RV32 only 5 bits.
          imm_full = (XLEN == 64) ? {58'b0, instr_i[25:20]} : {59'b0, instr_i[24:20]};
          type_o   = IMM_SHAMT;
        end else begin
          imm_full = sext32({{20{instr_i[31]}}, instr_i[31:20]});
          type_o   = IMM_I;
        end
      end
      OP_IMM32: begin
        // The word-sized ops only exist on RV64; on RV32 they decode as no immediate.
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            imm_full = {59'b0, instr_i[24:20]};
            type_o   = IMM_SHAMT;
          end else begin
            imm_full = sext32({{20{instr_i[31]}}, instr_i[31:20]});
            type_o   = IMM_I;
          end
        end
      end
      OP_SYSTEM: begin
        if (funct3 != 3'b100) begin
`ifdef IMM_CSR_UIMM_EN
          if (funct3[2]) begin
            imm_full = {59'b0, instr_i[19:15]};
            type_o   = IMM_UIMM;
          end else begin
            imm_full = sext32({{20{instr_i[31]}}, instr_i[31:20]});
            type_o   = IMM_I;
          end
`else
          imm_full = sext32({{20{instr_i[31]}}, instr_i[31:20]});
          type_o   = IMM_I;
`endif
        end
      end
      default: begin
        imm_full = '0;
        type_o   = IMM_NONE;
      end
    endcase
  end

  assign imm_o = imm_full[XLEN-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a 2-entry skid buffer
// (head = output register, skid = overflow register). ready_o comes straight from a flop.
// Optional feature macro: IMM_CSR_UIMM_EN (CSR immediate forms tagged IMM_UIMM).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int INST_W = INST_WIDTH
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [INST_W-1:0] instr_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] instr_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [2:0]        imm_type_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (INST_W != 32) begin : g_bad_inst_w
    $error("imm_gen_pipe: INST_W must be 32");
  end

  logic [XLEN-1:0]   dec_imm;
  imm_type_e         dec_type;

  logic              head_valid_q, head_valid_d;
  logic [INST_W-1:0] head_instr_q, head_instr_d;
  logic [XLEN-1:0]   head_imm_q,   head_imm_d;
  imm_type_e         head_type_q,  head_type_d;
  logic              skid_valid_q, skid_valid_d;
  logic [INST_W-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_imm_q,   skid_imm_d;
  imm_type_e         skid_type_q,  skid_type_d;

  logic              take_in;
  logic              take_out;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i (instr_i),
    .imm_o   (dec_imm),
    .type_o  (dec_type)
  );

  assign ready_o  = !skid_valid_q;
  assign take_in  = valid_i && ready_o;
  assign take_out = head_valid_q && ready_i;

  // Next-state of the two buffer entries; payloads only move on accept or skid->head.
  always_comb begin
    head_valid_d = head_valid_q;
    head_instr_d = head_instr_q;
    head_imm_d   = head_imm_q;
    head_type_d  = head_type_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
    if (flush_i) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || take_out) begin
      // Head is free this edge: refill from skid first (older), else from the input.
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_instr_d = skid_instr_q;
        head_imm_d   = skid_imm_q;
        head_type_d  = skid_type_q;
        skid_valid_d = 1'b0;
      end else if (take_in) begin
        head_valid_d = 1'b1;
        head_instr_d = instr_i;
        head_imm_d   = dec_imm;
        head_type_d  = dec_type;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (take_in) begin
      skid_valid_d = 1'b1;
      skid_instr_d = instr_i;
      skid_imm_d   = dec_imm;
      skid_type_d  = dec_type;
    end
  end

  // Buffer state registers; payloads are reset too so outputs read zero out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head_valid_q <= 1'b0;
      head_instr_q <= '0;
      head_imm_q   <= '0;
      head_type_q  <= IMM_NONE;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_imm_q   <= '0;
      skid_type_q  <= IMM_NONE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      head_valid_q <= head_valid_d;
      head_instr_q <= head_instr_d;
      head_imm_q   <= head_imm_d;
      head_type_q  <= head_type_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_imm_q   <= skid_imm_d;
      skid_type_q  <= skid_type_d;
    end
  end

  assign valid_o    = head_valid_q;
  assign instr_o    = head_instr_q;
  assign imm_o      = head_imm_q;
  assign imm_type_o = head_type_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed decode cases, back-pressure, flush,
// async reset, and a randomized stream against a queue-based reference model.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush, vin, rin;
  logic [31:0] ins;
  logic        ready_o, valid_o;
  logic [31:0] instr_o;
  logic [63:0] imm_o;
  logic [2:0]  typ_o;

  logic        vin32, flush32, rin32;
  logic [31:0] ins32;
  logic        ready32, valid32;
  logic [31:0] instr32;
  logic [31:0] imm32;
  logic [2:0]  typ32;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  typ;
  } exp_t;

  exp_t q[$];

  imm_gen_pipe #(.XLEN(64)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush), .valid_i(vin), .ready_o(ready_o),
    .instr_i(ins), .valid_o(valid_o), .ready_i(rin), .instr_o(instr_o),
    .imm_o(imm_o), .imm_type_o(typ_o)
  );

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush32), .valid_i(vin32), .ready_o(ready32),
    .instr_i(ins32), .valid_o(valid32), .ready_i(rin32), .instr_o(instr32),
    .imm_o(imm32), .imm_type_o(typ32)
  );

  // ---------------- reference model ----------------
  function automatic longint u(input logic [31:0] x);
    return longint'(x);
  endfunction

  // Interpret the low 'bits' bits of v as a two's-complement number.
  function automatic longint sext(input longint v, input int bits);
    if (((v >> (bits - 1)) & 1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic exp_t ref_model(input logic [31:0] i, input int xlen);
    exp_t        e;
    longint      v;
    logic [2:0]  t;
    logic [2:0]  f3;
    v  = 0;
    t  = IMM_NONE;
    f3 = i[14:12];
    case (i[6:0])
      OP_LUI, OP_AUIPC: begin v = sext(u(i[31:12]) * 4096, 32); t = IMM_U; end
      OP_JAL: begin
        v = sext(u(i[31]) * (1 << 20) + u(i[19:12]) * (1 << 12) + u(i[20]) * 2048 + u(i[30:21]) * 2, 21);
        t = IMM_J;
      end
      OP_JALR, OP_LOAD: begin v = sext(u(i[31:20]), 12); t = IMM_I; end
      OP_BRANCH: begin
        v = sext(u(i[31]) * 4096 + u(i[7]) * 2048 + u(i[30:25]) * 32 + u(i[11:8]) * 2, 13);
        t = IMM_B;
      end
      OP_STORE: begin v = sext(u(i[31:25]) * 32 + u(i[11:7]), 12); t = IMM_S; end
      OP_IMM: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          v = (xlen == 64) ? u(i[25:20]) : u(i[24:20]);
          t = IMM_SHAMT;
        end else begin
          v = sext(u(i[31:20]), 12); t = IMM_I;
        end
      end
      OP_IMM32: begin
        if (xlen == 64) begin
          if (f3 == 3'd1 || f3 == 3'd5) begin v = u(i[24:20]); t = IMM_SHAMT; end
          else begin v = sext(u(i[31:20]), 12); t = IMM_I; end
        end
      end
      OP_SYSTEM: begin
        if (f3 != 3'd4) begin
`ifdef IMM_CSR_UIMM_EN
          if (f3 >= 3'd5) begin v = u(i[19:15]); t = IMM_UIMM; end
          else begin v = sext(u(i[31:20]), 12); t = IMM_I; end
`else
          v = sext(u(i[31:20]), 12); t = IMM_I;
`endif
        end
      end
      default: begin v = 0; t = IMM_NONE; end
    endcase
    e.instr = i;
    e.imm   = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    e.typ   = t;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10];
    logic [31:0] r;
    int          k;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_SYSTEM};
    r = $urandom;
    k = $urandom_range(0, 10);
    if (k < 10) r[6:0] = ops[k];
    return r;
  endfunction

  // One accepted transfer with ready_i high; returns at negedge+1 with the entry on the outputs.
  task automatic send_one(input logic [31:0] i);
    @(negedge clk);
    vin = 1'b1; ins = i; rin = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; vin = 1'b0; rin = 1'b0; ins = '0;
    vin32 = 1'b0; flush32 = 1'b0; rin32 = 1'b1; ins32 = '0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({valid_o, ready_o, instr_o, imm_o, typ_o} !== {1'b0, 1'b1, 32'h0, 64'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b instr=%h imm=%h type=%0d, required 0 1 0 0 0",
               valid_o, ready_o, instr_o, imm_o, typ_o);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] vec  [6];
    logic [63:0] want_imm [6];
    logic [2:0]  want_typ [6];
    exp_t        e;
    vec = '{32'hFFF00093, 32'h03F01013, 32'h80000063, 32'h0020006F, 32'h340FD073, 32'h0050109B};
    want_imm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'hFFFF_FFFF_FFFF_F000, 64'd2,
`ifdef IMM_CSR_UIMM_EN
                 64'd31,
`else
                 64'h340,
`endif
                 64'd5};
    want_typ = '{IMM_I, IMM_SHAMT, IMM_B, IMM_J,
`ifdef IMM_CSR_UIMM_EN
                 IMM_UIMM,
`else
                 IMM_I,
`endif
                 IMM_SHAMT};
    for (int k = 0; k < 6; k++) begin
      send_one(vec[k]);
      e = ref_model(vec[k], 64);
      n_checks++;
      if (valid_o !== 1'b1 || instr_o !== vec[k] || imm_o !== want_imm[k] || typ_o !== want_typ[k]) begin
        n_fail++;
        $display("FAIL directed_%0d: valid=%b instr=%h imm=%h type=%0d, required 1 %h %h %0d",
                 k, valid_o, instr_o, imm_o, typ_o, vec[k], want_imm[k], want_typ[k]);
      end
      n_checks++;
      if (imm_o !== e.imm || typ_o !== e.typ) begin
        n_fail++;
        $display("FAIL directed_model_%0d: imm=%h type=%0d, required %h %0d", k, imm_o, typ_o, e.imm, e.typ);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_xlen32();
    @(negedge clk);
    vin32 = 1'b1; ins32 = 32'h0050109B;
    @(posedge clk);
    @(negedge clk);
    vin32 = 1'b0;
    #1;
    n_checks++;
    if (valid32 !== 1'b1 || imm32 !== 32'h0 || typ32 !== IMM_NONE) begin
      n_fail++;
      $display("FAIL xlen32_slliw: valid=%b imm=%h type=%0d, required 1 0 0", valid32, imm32, typ32);
    end
    @(negedge clk);
    vin32 = 1'b1; ins32 = 32'hFFF00093;
    @(posedge clk);
    @(negedge clk);
    vin32 = 1'b0;
    #1;
    n_checks++;
    if (imm32 !== 32'hFFFF_FFFF || typ32 !== IMM_I) begin
      n_fail++;
      $display("FAIL xlen32_addi: imm=%h type=%0d, required ffffffff 1", imm32, typ32);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    a = 32'h00100093; b = 32'h00200113; c = 32'h00300193;
    @(negedge clk);
    rin = 1'b0; vin = 1'b1; ins = a;
    @(posedge clk);
    @(negedge clk);
    ins = b;
    #1;
    n_checks++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_2nd: ready=%b, required 1", ready_o); end
    @(posedge clk);
    @(negedge clk);
    ins = c;
    #1;
    n_checks++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_3rd: ready=%b, required 0", ready_o); end
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0; rin = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || instr_o !== a) begin
      n_fail++; $display("FAIL b2b_first_out: valid=%b instr=%h, required 1 %h", valid_o, instr_o, a);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_o !== 1'b1 || instr_o !== b || imm_o !== 64'd2 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second_out: valid=%b instr=%h imm=%h ready=%b, required 1 %h 2 1",
                         valid_o, instr_o, imm_o, ready_o, b);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: valid=%b instr=%h, required 0", valid_o, instr_o); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    rin = 1'b0; vin = 1'b1; ins = 32'h00100093;
    @(posedge clk);
    @(negedge clk);
    ins = 32'h00200113;
    @(posedge clk);
    @(negedge clk);
    ins = 32'h00300193; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0; flush = 1'b0; rin = 1'b1;
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_full: valid=%b ready=%b, required 0 1", valid_o, ready_o);
    end
    // Empty buffer, accept and flush on the same edge: the input must be dropped.
    @(negedge clk);
    vin = 1'b1; ins = 32'h00400213; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (valid_o !== 1'b0) begin
        n_fail++; $display("FAIL flush_drop_%0d: valid=%b instr=%h, required 0", k, valid_o, instr_o);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic in_fire, out_fire;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      vin   = ($urandom_range(0, 99) < 70);
      ins   = rand_instr();
      rin   = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 3);
      #1;
      n_checks++;
      if (ready_o !== (q.size() < 2) || valid_o !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL rand_flags cyc %0d: ready=%b valid=%b, required %b %b",
                 cyc, ready_o, valid_o, q.size() < 2, q.size() > 0);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (instr_o !== q[0].instr || imm_o !== q[0].imm || typ_o !== q[0].typ) begin
          n_fail++;
          $display("FAIL rand_payload cyc %0d: instr=%h imm=%h type=%0d, required %h %h %0d",
                   cyc, instr_o, imm_o, typ_o, q[0].instr, q[0].imm, q[0].typ);
        end
      end
      in_fire  = vin && ready_o;
      out_fire = valid_o && rin;
      if (out_fire && q.size() > 0) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_fire) q.push_back(ref_model(ins, 64));
    end
    @(negedge clk);
    vin = 1'b0; flush = 1'b0; rin = 1'b1;
    repeat (3) @(negedge clk);
    q.delete();
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    rin = 1'b0; vin = 1'b1; ins = 32'h00500293;
    @(posedge clk);
    @(negedge clk);
    ins = 32'h00600313;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({valid_o, ready_o, instr_o, imm_o, typ_o} !== {1'b0, 1'b1, 32'h0, 64'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b ready=%b instr=%h imm=%h type=%0d, required 0 1 0 0 0",
               valid_o, ready_o, instr_o, imm_o, typ_o);
    end
    @(negedge clk);
    rstn = 1'b1; rin = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: valid=%b ready=%b, required 0 1", valid_o, ready_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_xlen32();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
